// File: rtl/instruction_loader.sv
// instruction_loader
//   Fills the instruction RAM from a byte stream before the CPU is released.
//   Stream format: 16-bit word count (MSB first), then that many 32-bit
//   instructions, each MSB first. One imem write is issued per instruction.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start, CPU free
//   LEN_HI  | expecting word-count high byte
//   LEN_LO  | expecting word-count low byte, count is validated here
//   WORD    | collecting the 4 bytes of one instruction
//   WRITE   | one-cycle imem write of the packed instruction
//   DONE    | load finished, CPU released, waits for start
//   ERROR   | illegal word count, CPU kept held, waits for start
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a load (honoured in IDLE/DONE/ERROR)
//   byte_valid, byte_data      incoming stream byte
//   byte_ready                 loader accepts a byte this cycle
//   imem_we/addr/wdata         instruction RAM write port
//   cpu_hold                   CPU reset/stall request
//   busy, done, error          load status
module instruction_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_WORDS  = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_DONE, S_ERROR
   } state_t;

   localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

   state_t              state, state_nxt;
   logic [15:0]         len_q;
   logic [ADDR_WIDTH:0] idx_q;
   logic [1:0]          bcnt_q;
   logic [31:0]         shift_q;
   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;

   logic                xfer;
   logic [15:0]         len_full;
   logic                last_word;
   logic [31:0]         shift_nxt;

   assign xfer      = byte_valid & byte_ready;
   // Full count as it will be once the low byte lands this cycle.
   assign len_full  = {len_q[15:8], byte_data};
   assign last_word = (16'(idx_q) == len_q - 16'd1);
   assign shift_nxt = {shift_q[23:0], byte_data};

   // All status outputs are pure state decodes, so byte_valid never
   // reaches an output combinationally.
   assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_WORD);
   assign imem_we    = (state == S_WRITE);
   assign busy       = byte_ready || (state == S_WRITE);
   assign cpu_hold   = busy || (state == S_ERROR);
   assign done       = (state == S_DONE);
   assign error      = (state == S_ERROR);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_LEN_HI;
         S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (xfer) begin
               if (len_full == 16'd0)                 state_nxt = S_DONE;
               else if (len_full > 16'(MAX_WORDS))    state_nxt = S_ERROR;
               else                                   state_nxt = S_WORD;
            end
         end
         S_WORD:   if (xfer && bcnt_q == 2'd3) state_nxt = S_WRITE;
         S_WRITE:  state_nxt = last_word ? S_DONE : S_WORD;
         S_DONE:   if (start) state_nxt = S_LEN_HI;
         S_ERROR:  if (start) state_nxt = S_LEN_HI;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_LEN_HI: if (xfer) len_q[15:8] <= byte_data;
            S_LEN_LO: begin
               if (xfer) begin
                  len_q[7:0] <= byte_data;
                  idx_q      <= '0;
                  bcnt_q     <= '0;
               end
            end
            S_WORD: begin
               if (xfer) begin
                  shift_q <= shift_nxt;
                  bcnt_q  <= bcnt_q + 2'd1;
                  // Capture address and data on the 4th byte so both are
                  // stable for the whole WRITE cycle and hold afterwards.
                  if (bcnt_q == 2'd3) begin
                     addr_q  <= 32'({idx_q[ADDR_WIDTH-1:0], 2'b00});
                     wdata_q <= shift_nxt;
                  end
               end
            end
            S_WRITE: begin
               idx_q  <= idx_q + IDX_ONE;
               bcnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
